dot_renderer: RTL and testbench
===============================

Name: dot_renderer

Overview:
- Reads the 90-bit dot map produced by the dot bookkeeping logic and turns it into per-pixel dot video for the VGA mixer.
- Snapshots the map once per frame, which prevents tearing.
- Maps the scan position to an 18x5 tile grid and draws a square pellet in each tile whose bit is set.
- Blinks the remaining dots when few are left.
- Sits between the dot counter and the pixel colour mux, alongside the sprite renderers.

Parameters:
- MAP_X0, 32, left pixel edge of the tile grid.
- MAP_Y0, 160, top pixel edge of the tile grid.
- TILE_LOG2, 5, log2 of the tile size. Tile is 32x32 px.
- DOT_LO, 13, first in-tile pixel offset of the pellet (both axes).
- DOT_HI, 18, last in-tile pixel offset of the pellet (inclusive).
- BLINK_THRESH, 5, blinking is enabled when dot_cnt <= this value and dot_cnt != 0.
- BLINK_LOG2, 4, number of frames per blink half-period, as log2 (16 frames).
- DOT_COLOR, 12'hFC8, RGB444 pellet colour.

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  synchronous active-low reset
- scene  in  2  00 start, 01 play, 10 win, 11 lose
- dot  in  [0:89]  live dot map; bit index = col + row*18; dot[0] is top-left
- dot_cnt  in  6  remaining dot count
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- video_on  in  1  active-video flag for pix_x/pix_y
- pix_x  in  10  current scan column
- pix_y  in  10  current scan row
- dot_pixel  out  1  pellet present at the delayed pixel
- dot_rgb  out  12  DOT_COLOR when dot_pixel is 1, else 0
- video_on_d  out  1  video_on delayed to align with dot_pixel

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - shadow map <= 0
  - frame counter <= 0
  - all pipeline registers <= 0
  - dot_pixel = 0, dot_rgb = 0, video_on_d = 0 from the next edge
  - Reset mid-frame discards in-flight pixels.
- Shadow map:
  - On a clk edge with frame_start=1, shadow <= dot.
  - Changes to dot at any other time do not affect output until the next frame_start.
- Frame counter: 8-bit. Increments on each frame_start and wraps 255 -> 0.
- Blink phase:
  - blink_off = frame_cnt[BLINK_LOG2].
  - Blink applies only when 0 < dot_cnt <= BLINK_THRESH, with dot_cnt sampled in stage 1.
  - While blink applies and blink_off = 1, all dots are suppressed.
- Stage 1 (edge N), from pix_x/pix_y:
  - rx = pix_x - MAP_X0, ry = pix_y - MAP_Y0, both 10-bit.
  - in_map = (pix_x >= MAP_X0) and (pix_x < MAP_X0 + 18*32) and (pix_y >= MAP_Y0) and (pix_y < MAP_Y0 + 5*32).
  - col = rx >> TILE_LOG2 (5 bits); row = ry >> TILE_LOG2 (3 bits).
  - in_dot = (DOT_LO <= rx[4:0] <= DOT_HI) and (DOT_LO <= ry[4:0] <= DOT_HI).
  - Also registers: scene_en = (scene==01 or scene==11), blink suppress flag, video_on.
- Stage 2 (edge N+1):
  - idx = col + row*18, 7 bits, always < 90 when in_map.
  - dot_pixel <= video_on_s1 & in_map & in_dot & shadow[idx] & scene_en & ~suppress.
  - dot_rgb <= DOT_COLOR if that term is 1, else 0.
  - video_on_d <= video_on_s1.
- Latency: exactly 2 clocks from pix_x/pix_y/video_on to outputs. Fully pipelined, one pixel per clock, no stalls.
- Out-of-map pixels never read the shadow. Out-of-range idx yields 0.
- frame_start and video_on both 1 in the same cycle:
  - shadow updates on that edge.
  - The pixel in stage 2 at that edge uses the pre-update shadow.
- Scene start or win: dot_pixel is forced to 0 regardless of the shadow.
- dot_cnt = 0: no blink, and the shadow is all 0 in practice.

Test Plan:
- Reset, dot[0]=1, pulse frame_start, scene=01, dot_cnt=57, drive (pix_x,pix_y)=(45,173) with video_on=1 -> dot_pixel=1, dot_rgb=12'hFC8 exactly 2 clocks later. (44,173) -> 0. (51,173) -> 0.
- dot[89]=1 only, frame_start, pixel (32+17*32+15, 160+4*32+15)=(591,303) -> 1. (608,303) and (591,320) lie outside the map -> 0.
- Set dot[18]=1 without frame_start, pixel (45,205) -> 0. Pulse frame_start, repeat -> 1. Clear dot[18] mid-frame -> still 1 until the next frame_start.
- dot_cnt=3, dot[0]=1, pixel (45,173):
  - frames with frame_cnt 0-15 -> 1
  - frames 16-31 -> 0
  - frames 32-47 -> 1
  - with dot_cnt=6 -> 1 in all frames.
- scene=00 or 10 with dot[0] set, pixel (45,173) -> 0. scene=11 -> 1. video_on=0 -> 0, with video_on_d tracking video_on at 2-cycle delay.
- Stream pixels, assert rst_n=0 for 1 clock mid-stream -> outputs 0 on the following edges, shadow cleared. A subsequent pixel (45,173) with no new frame_start -> 0.

Source files
------------

// File: rtl/dot_renderer.sv
// Dot pellet renderer: per-frame snapshot of the 90-bit dot map,
// 18x5 tile grid lookup and blink gating, two-clock pixel pipeline.
module dot_renderer #(
  parameter int          MAP_X0       = 32,
  parameter int          MAP_Y0       = 160,
  parameter int          TILE_LOG2    = 5,
  parameter int          DOT_LO       = 13,
  parameter int          DOT_HI       = 18,
  parameter int          BLINK_THRESH = 5,
  parameter int          BLINK_LOG2   = 4,
  parameter logic [11:0] DOT_COLOR    = 12'hFC8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  scene,
  input  logic [0:89] dot,
  input  logic [5:0]  dot_cnt,
  input  logic        frame_start,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        dot_pixel,
  output logic [11:0] dot_rgb,
  output logic        video_on_d
);

  localparam logic [9:0] X0 = 10'(MAP_X0);
  localparam logic [9:0] Y0 = 10'(MAP_Y0);
  localparam logic [9:0] X1 = 10'(MAP_X0 + (18 << TILE_LOG2));
  localparam logic [9:0] Y1 = 10'(MAP_Y0 + (5 << TILE_LOG2));
  localparam logic [4:0] LO = 5'(DOT_LO);
  localparam logic [4:0] HI = 5'(DOT_HI);
  localparam logic [5:0] BT = 6'(BLINK_THRESH);

  logic [0:89] shadow;
  logic [7:0]  frame_cnt;

  logic       s1_in_map;
  logic       s1_in_dot;
  logic       s1_scene_en;
  logic       s1_supp;
  logic       s1_vo;
  logic [4:0] s1_col;
  logic [2:0] s1_row;

  logic [9:0] rx;
  logic [9:0] ry;
  logic [9:0] cx;
  logic [9:0] cy;
  logic       in_map;
  logic       in_dot;
  logic       supp;
  logic [6:0] idx;
  logic       hit;

  // Stage 1 address decode and blink gating
  always_comb begin
    rx     = pix_x - X0;
    ry     = pix_y - Y0;
    cx     = rx >> TILE_LOG2;
    cy     = ry >> TILE_LOG2;
    in_map = (pix_x >= X0) && (pix_x < X1) &&
             (pix_y >= Y0) && (pix_y < Y1);
    in_dot = (rx[4:0] >= LO) && (rx[4:0] <= HI) &&
             (ry[4:0] >= LO) && (ry[4:0] <= HI);
    supp   = (dot_cnt != 6'd0) && (dot_cnt <= BT) &&
             frame_cnt[BLINK_LOG2];
  end

  // Stage 2 map lookup; out-of-map pixels never touch the shadow
  always_comb begin
    idx = {2'b00, s1_col} + ({4'b0000, s1_row} * 7'd18);
    hit = 1'b0;
    if (s1_in_map && idx < 7'd90)
      hit = shadow[idx];
  end

  // Frame snapshot of the dot map and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      shadow    <= dot;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in_map   <= 1'b0;
      s1_in_dot   <= 1'b0;
      s1_scene_en <= 1'b0;
      s1_supp     <= 1'b0;
      s1_vo       <= 1'b0;
      s1_col      <= 5'd0;
      s1_row      <= 3'd0;
    end else begin
      s1_in_map   <= in_map;
      s1_in_dot   <= in_dot;
      s1_scene_en <= scene[0];
      s1_supp     <= supp;
      s1_vo       <= video_on;
      s1_col      <= cx[4:0];
      s1_row      <= cy[2:0];
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot_pixel  <= 1'b0;
      dot_rgb    <= 12'd0;
      video_on_d <= 1'b0;
    end else begin
      dot_pixel  <= s1_vo & s1_in_dot & hit &
                    s1_scene_en & ~s1_supp;
      dot_rgb    <= (s1_vo & s1_in_dot & hit &
                     s1_scene_en & ~s1_supp) ?
                    DOT_COLOR : 12'd0;
      video_on_d <= s1_vo;
    end
  end

endmodule

// File: tb/tb_dot_renderer.sv
// Self-checking bench for dot_renderer: table vectors, hand
// sequences for frame/blink/reset corners, and random stimulus.
module tb_dot_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  scene;
  logic [0:89] dot;
  logic [5:0]  dot_cnt;
  logic        frame_start;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        dot_pixel;
  logic [11:0] dot_rgb;
  logic        video_on_d;

  int checks = 0;
  int failures = 0;

  logic [0:89] sh_m;
  int  fc_m;
  bit  p_base;
  int  p_idx;
  bit  p_vo;
  bit  e_pix;
  bit  e_vo;

  typedef struct {
    int         px;
    int         py;
    logic [1:0] sc;
    logic [5:0] dc;
    bit         vo;
    bit         exp;
  } vec_t;

  vec_t vecs[12];

  dot_renderer dut (
    .clk(clk),
    .rst_n(rst_n),
    .scene(scene),
    .dot(dot),
    .dot_cnt(dot_cnt),
    .frame_start(frame_start),
    .video_on(video_on),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .dot_pixel(dot_pixel),
    .dot_rgb(dot_rgb),
    .video_on_d(video_on_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model predicts what the outputs
  // must be after this edge from the spec's arithmetic rules.
  task automatic cyc();
    bit nb;
    int rx;
    int ry;
    e_pix = p_base && sh_m[p_idx];
    e_vo  = p_vo;
    rx = int'(pix_x) - 32;
    ry = int'(pix_y) - 160;
    nb = video_on &&
         rx >= 0 && rx < 576 && ry >= 0 && ry < 160 &&
         (rx % 32) >= 13 && (rx % 32) <= 18 &&
         (ry % 32) >= 13 && (ry % 32) <= 18 &&
         (scene == 2'b01 || scene == 2'b11) &&
         !(dot_cnt != 0 && dot_cnt <= 5 &&
           ((fc_m / 16) % 2) == 1);
    p_idx  = nb ? (rx / 32) + (ry / 32) * 18 : 0;
    p_base = nb;
    p_vo   = video_on;
    if (frame_start) begin
      sh_m = dot;
      fc_m = (fc_m + 1) % 256;
    end
    if (!rst_n) begin
      sh_m   = '0;
      fc_m   = 0;
      p_base = 0;
      p_idx  = 0;
      p_vo   = 0;
      e_pix  = 0;
      e_vo   = 0;
    end
    @(posedge clk);
    #1;
    chk("pix", {11'd0, dot_pixel}, {11'd0, e_pix});
    chk("rgb", dot_rgb, e_pix ? 12'hFC8 : 12'h000);
    chk("vod", {11'd0, video_on_d}, {11'd0, e_vo});
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    video_on = 1'b0;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic one_pix(input string name, input int px,
                         input int py, input bit exp);
    pix_x = 10'(px);
    pix_y = 10'(py);
    video_on = 1'b1;
    cyc();
    pix_x = 10'd0;
    pix_y = 10'd0;
    cyc();
    chk(name, {11'd0, dot_pixel}, {11'd0, exp});
    chk({name, "_rgb"}, dot_rgb, exp ? 12'hFC8 : 12'h000);
  endtask

  initial begin
    rst_n = 1'b0;
    scene = 2'b01;
    dot = '0;
    dot_cnt = 6'd57;
    frame_start = 1'b0;
    video_on = 1'b0;
    pix_x = 10'd0;
    pix_y = 10'd0;
    sh_m = '0;
    fc_m = 0;
    p_base = 0;
    p_idx = 0;
    p_vo = 0;
    #1;
    cyc();
    cyc();
    chk("reset_pix", {11'd0, dot_pixel}, 12'd0);
    chk("reset_rgb", dot_rgb, 12'd0);
    rst_n = 1'b1;

    vecs[0]  = '{45, 173, 2'b01, 6'd57, 1'b1, 1'b1};
    vecs[1]  = '{44, 173, 2'b01, 6'd57, 1'b1, 1'b0};
    vecs[2]  = '{51, 173, 2'b01, 6'd57, 1'b1, 1'b0};
    vecs[3]  = '{50, 178, 2'b01, 6'd57, 1'b1, 1'b1};
    vecs[4]  = '{45, 172, 2'b01, 6'd57, 1'b1, 1'b0};
    vecs[5]  = '{77, 173, 2'b01, 6'd57, 1'b1, 1'b0};
    vecs[6]  = '{45, 173, 2'b00, 6'd57, 1'b1, 1'b0};
    vecs[7]  = '{45, 173, 2'b10, 6'd57, 1'b1, 1'b0};
    vecs[8]  = '{45, 173, 2'b11, 6'd57, 1'b1, 1'b1};
    vecs[9]  = '{45, 173, 2'b01, 6'd57, 1'b0, 1'b0};
    vecs[10] = '{45, 173, 2'b01, 6'd3,  1'b1, 1'b1};
    vecs[11] = '{13, 13,  2'b01, 6'd57, 1'b1, 1'b0};

    dot[0] = 1'b1;
    pulse();
    foreach (vecs[i]) begin
      scene = vecs[i].sc;
      dot_cnt = vecs[i].dc;
      pix_x = 10'(vecs[i].px);
      pix_y = 10'(vecs[i].py);
      video_on = vecs[i].vo;
      cyc();
      pix_x = 10'd0;
      pix_y = 10'd0;
      video_on = 1'b1;
      cyc();
      chk($sformatf("vec%0d", i), {11'd0, dot_pixel},
          {11'd0, vecs[i].exp});
    end
    scene = 2'b01;
    dot_cnt = 6'd57;

    dot = '0;
    dot[89] = 1'b1;
    pulse();
    one_pix("last_tile", 591, 303, 1'b1);
    one_pix("right_edge", 608, 303, 1'b0);
    one_pix("bottom_edge", 591, 320, 1'b0);

    dot = '0;
    dot[18] = 1'b1;
    one_pix("no_snap", 45, 205, 1'b0);
    pulse();
    one_pix("snap", 45, 205, 1'b1);
    dot[18] = 1'b0;
    one_pix("hold", 45, 205, 1'b1);
    pulse();
    one_pix("cleared", 45, 205, 1'b0);

    do_reset();
    dot = '0;
    dot[0] = 1'b1;
    dot_cnt = 6'd3;
    pulse();
    one_pix("blink_f1", 45, 173, 1'b1);
    repeat (19) pulse();
    one_pix("blink_f20", 45, 173, 1'b0);
    dot_cnt = 6'd6;
    one_pix("noblink6_f20", 45, 173, 1'b1);
    dot_cnt = 6'd0;
    one_pix("noblink0_f20", 45, 173, 1'b1);
    dot_cnt = 6'd3;
    repeat (20) pulse();
    one_pix("blink_f40", 45, 173, 1'b1);

    dot_cnt = 6'd57;
    pix_x = 10'd45;
    pix_y = 10'd173;
    video_on = 1'b1;
    repeat (4) cyc();
    chk("stream_on", {11'd0, dot_pixel}, 12'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_pix0", {11'd0, dot_pixel}, 12'd0);
    chk("rst_vod0", {11'd0, video_on_d}, 12'd0);
    cyc();
    chk("rst_pix1", {11'd0, dot_pixel}, 12'd0);
    one_pix("rst_shadow", 45, 173, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        pix_x = 10'(32 + 32 * $urandom_range(0, 17) +
                    $urandom_range(11, 20));
        pix_y = 10'(160 + 32 * $urandom_range(0, 4) +
                    $urandom_range(11, 20));
      end else begin
        pix_x = 10'($urandom_range(0, 639));
        pix_y = 10'($urandom_range(140, 340));
      end
      video_on = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 99) == 0)
        scene = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        dot_cnt = ($urandom_range(0, 3) == 0) ? 6'd57 :
                  6'($urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0)
        for (int b = 0; b < 90; b++)
          dot[b] = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
